// File: rtl/mux_soma_pkg.sv
// mux_soma_pkg: shared types for the mux/add/accumulate datapath
package mux_soma_pkg;
    typedef enum logic [1:0] {OP_ADD, OP_ACC, OP_CLR, OP_LOAD} op_e;
endpackage

// File: rtl/mux_n.sv
// mux_n: combinational NCH-to-1 mux; out-of-range selects yield zero and raise err
module mux_n #(
    parameter int WIDTH = 4,
    parameter int NCH = 2
) (
    input  logic [NCH-1:0][WIDTH-1:0] ch,
    input  logic [$clog2(NCH)-1:0]    sel,
    output logic [WIDTH-1:0]          m,
    output logic                      err
);
    always_comb begin
        m = '0;
        for (int k = 0; k < NCH; k++) m = 32'(sel) == k ? ch[k] : m;
        err = 32'(sel) >= NCH;
    end
endmodule

// File: rtl/mux_soma_acc.sv
// mux_soma_acc: selectable-channel add/accumulate behind a two-stage valid/ready pipeline
module mux_soma_acc
    import mux_soma_pkg::*;
#(
    parameter int WIDTH = 4,
    parameter int NCH = 2,
    parameter int SAT = 0
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic [WIDTH-1:0]          a,
    input  logic [NCH-1:0][WIDTH-1:0] ch,
    input  logic [$clog2(NCH)-1:0]    sel,
    input  logic [1:0]                op,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [WIDTH-1:0]          res,
    output logic                      carry,
    output logic                      err
);
    op_e s1_op;
    logic s1_valid, s1_err, s2_valid, s1_adv, s2_adv, mux_err, nxt_carry;
    logic [WIDTH-1:0] s1_a, s1_m, acc, m, nxt_res;
    logic [WIDTH:0] sum;
    mux_n #(.WIDTH(WIDTH), .NCH(NCH)) u_mux (.ch(ch), .sel(sel), .m(m), .err(mux_err));
    assign s2_adv = !s2_valid || out_ready;
    assign s1_adv = !s1_valid || s2_adv;
    assign in_ready = s1_adv;
    assign out_valid = s2_valid;
    // acc is only touched here, so back-to-back ACCs chain through stage 2 directly
    always_comb begin
        sum = {1'b0, (s1_op == OP_ADD ? s1_a : acc)} + {1'b0, s1_m};
        nxt_carry = (s1_op == OP_ADD || s1_op == OP_ACC) && sum[WIDTH];
        nxt_res = s1_op == OP_CLR ? '0 :
                  s1_op == OP_LOAD ? s1_m :
                  (SAT != 0 && sum[WIDTH]) ? '1 : sum[WIDTH-1:0];
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid <= 1'b0;
            s1_op <= OP_ADD;
            s1_a <= '0;
            s1_m <= '0;
            s1_err <= 1'b0;
            s2_valid <= 1'b0;
            res <= '0;
            carry <= 1'b0;
            err <= 1'b0;
            acc <= '0;
        end else begin
            if (s1_adv) begin
                s1_valid <= in_valid;
                if (in_valid) begin
                    s1_op <= op_e'(op);
                    s1_a <= a;
                    s1_m <= m;
                    s1_err <= mux_err;
                end
            end
            if (s2_adv) begin
                s2_valid <= s1_valid;
                if (s1_valid) begin
                    res <= nxt_res;
                    carry <= nxt_carry;
                    err <= s1_err;
                    if (s1_op != OP_ADD) acc <= nxt_res;
                end
            end
        end
    end
endmodule
